pc_sequencer: RTL

Program-counter sequencer for the single-issue CPU. It owns the PC register and decides each cycle whether to increment, hold on memory busy-wait, or redirect to a branch/jump target. The target is computed from the decoded control flags and an 8-bit word offset. It sits between the control unit/decoder and the instruction memory. It replaces ad-hoc next-PC muxing with a stall-aware state machine that never loses a taken redirect.

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC. Each cycle it increments, holds while
// memory is busy, or redirects to a branch/jump target. A redirect decoded
// during a stall is parked in a pending register so it is never lost.
module pc_sequencer #(
    parameter int                    PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC     = 32'h0000_0000,
    parameter int                    OFFSET_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    busywait_i,
    input  logic                    dec_valid_i,
    input  logic                    branch_i,
    input  logic                    bne_i,
    input  logic                    jump_i,
    input  logic                    zero_i,
    input  logic [OFFSET_WIDTH-1:0] offset_i,
    output logic [PC_WIDTH-1:0]     pc_o,
    output logic [PC_WIDTH-1:0]     pc_plus4_o,
    output logic                    fetch_en_o,
    output logic                    flush_o,
    output logic                    taken_o,
    output logic [1:0]              state_o
);

    // state_o exposes the FSM encoding for observation:
    // 0 = BOOT, 1 = RUN, 2 = HOLD, 3 = HOLD_REDIR.
    typedef enum logic [1:0] {
        S_BOOT       = 2'd0,
        S_RUN        = 2'd1,
        S_HOLD       = 2'd2,
        S_HOLD_REDIR = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pending_q, pending_d;
    logic                flush_q, taken_q;
    logic                redirect_d;

    logic                taken_cond;
    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_plus4;

    // Redirect decision and target arithmetic (all modulo 2^PC_WIDTH).
    // pc_q already points one word past the decoded instruction.
    always_comb begin
        taken_cond = dec_valid_i & ((branch_i & zero_i) | (bne_i & ~zero_i) | jump_i);
        offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){offset_i[OFFSET_WIDTH-1]}}, offset_i};
        target     = pc_q + (offset_ext << 2);
        pc_plus4   = pc_q + PC_WIDTH'(4);
    end

    // Next-state, next-PC and fetch enable. BOOT spends one idle cycle so the
    // first fetch of RESET_PC happens in RUN; HOLD_REDIR ignores the decode
    // flags because decode is stalled on the instruction already latched.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        redirect_d = 1'b0;
        fetch_en_o = 1'b1;
        case (state_q)
            S_BOOT: begin
                fetch_en_o = 1'b0;
                state_d    = S_RUN;
            end
            S_RUN, S_HOLD: begin
                if (!busywait_i) begin
                    state_d = S_RUN;
                    if (taken_cond) begin
                        pc_d       = target;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else if (taken_cond) begin
                    pending_d = target;
                    state_d   = S_HOLD_REDIR;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD_REDIR: begin
                if (!busywait_i) begin
                    pc_d       = pending_q;
                    redirect_d = 1'b1;
                    state_d    = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State, PC, pending target and the one-cycle redirect pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            pending_q <= '0;
            flush_q   <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            flush_q   <= redirect_d;
            taken_q   <= redirect_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;
    assign flush_o    = flush_q;
    assign taken_o    = taken_q;
    assign state_o    = state_q;

endmodule
